// File: rtl/rob_commit_reader.sv
// Commit reader for a reorder buffer: walks completed entries in index order from head,
// fetches their payload from a registered-read memory and presents them through a 2-entry buffer.
module rob_commit_reader #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  done_en_i,
  input  logic [ADDR_WIDTH-1:0] done_idx_i,
  input  logic                  flush_i,
  output logic [ADDR_WIDTH-1:0] addr_read_o,
  input  logic [DATA_WIDTH-1:0] data_read_i,
  output logic                  commit_valid_o,
  input  logic                  commit_ready_i,
  output logic [DATA_WIDTH-1:0] commit_data_o,
  output logic [ADDR_WIDTH-1:0] commit_idx_o
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DEPTH-1:0]      done_q, done_d;
  logic [ADDR_WIDTH-1:0] head_q, head_d;
  logic                  in_flight_q, in_flight_d;
  logic [ADDR_WIDTH-1:0] flight_idx_q, flight_idx_d;
  logic [1:0]            count_q, count_d;
  logic                  rd_ptr_q, rd_ptr_d;
  logic [DATA_WIDTH-1:0] slot_data_q [2];
  logic [ADDR_WIDTH-1:0] slot_idx_q  [2];

  logic       pop;
  logic       push;
  logic       issue;
  logic       wr_ptr;
  logic [2:0] occupancy;

  // A push never lands on a full buffer: issue only happens when the slot is guaranteed.
  assign wr_ptr = rd_ptr_q ^ count_q[0];
  assign push   = in_flight_q;
  assign pop    = commit_valid_o && commit_ready_i;

  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is inferred.
    occupancy    = {2'b00, in_flight_q} + {1'b0, count_q} - {2'b00, pop};
    issue        = done_q[head_q] && !flush_i && (occupancy < 3'd2);
    done_d       = done_q;
    head_d       = head_q;
    in_flight_d  = issue;
    flight_idx_d = flight_idx_q;
    count_d      = count_q + {1'b0, push} - {1'b0, pop};
    rd_ptr_d     = rd_ptr_q ^ pop;

    if (issue) begin
      done_d[head_q] = 1'b0;
      head_d         = head_q + 1'b1;
      flight_idx_d   = head_q;
    end
    // A completion on the index being issued this cycle must survive the clear.
    if (done_en_i) begin
      done_d[done_idx_i] = 1'b1;
    end

    if (flush_i) begin
      done_d      = '0;
      head_d      = '0;
      in_flight_d = 1'b0;
      count_d     = 2'd0;
      rd_ptr_d    = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      done_q       <= '0;
      head_q       <= '0;
      in_flight_q  <= 1'b0;
      flight_idx_q <= '0;
      count_q      <= 2'd0;
      rd_ptr_q     <= 1'b0;
    end else begin
      done_q       <= done_d;
      head_q       <= head_d;
      in_flight_q  <= in_flight_d;
      flight_idx_q <= flight_idx_d;
      count_q      <= count_d;
      rd_ptr_q     <= rd_ptr_d;
    end
  end

  // NOTE: payload slots carry no reset; the outputs are masked whenever the buffer is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      slot_data_q[wr_ptr] <= data_read_i;
      slot_idx_q[wr_ptr]  <= flight_idx_q;
    end
  end

  assign addr_read_o    = head_q;
  assign commit_valid_o = (count_q != 2'd0);
  assign commit_data_o  = commit_valid_o ? slot_data_q[rd_ptr_q] : '0;
  assign commit_idx_o   = commit_valid_o ? slot_idx_q[rd_ptr_q]  : '0;

endmodule

// File: tb/tb_rob_commit_reader.sv
// Bench for rob_commit_reader: registered-read memory model plus a scoreboard of expected commits.
module tb_rob_commit_reader;

  localparam int AW    = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          done_en;
  logic [AW-1:0] done_idx;
  logic          flush;
  logic [AW-1:0] addr_read;
  logic [DW-1:0] data_read;
  logic          commit_valid;
  logic          commit_ready;
  logic [DW-1:0] commit_data;
  logic [AW-1:0] commit_idx;

  logic [DW-1:0] mem [DEPTH];

  typedef struct packed {
    logic [AW-1:0] idx;
    logic [DW-1:0] data;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  always @(posedge clk) data_read <= mem[addr_read];

  rob_commit_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk            (clk),
    .rst            (rst),
    .done_en_i      (done_en),
    .done_idx_i     (done_idx),
    .flush_i        (flush),
    .addr_read_o    (addr_read),
    .data_read_i    (data_read),
    .commit_valid_o (commit_valid),
    .commit_ready_i (commit_ready),
    .commit_data_o  (commit_data),
    .commit_idx_o   (commit_idx)
  );

  // Scoreboard: every accepted transfer must match the oldest expected entry.
  always @(negedge clk) begin
    if (rst === 1'b0 && commit_valid === 1'b1 && commit_ready === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_commit: got idx=%0d data=%h, none expected", commit_idx, commit_data);
      end else begin
        mon_e = exp_q.pop_front();
        if (commit_idx !== mon_e.idx || commit_data !== mon_e.data) begin
          errors++;
          $display("FAIL commit_entry: got idx=%0d data=%h, expected idx=%0d data=%h",
                   commit_idx, commit_data, mon_e.idx, mon_e.data);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic set_pattern(input logic [DW-1:0] mask);
    for (int i = 0; i < DEPTH; i++) mem[i] = DW'(i) ^ mask;
  endtask

  task automatic mark_done(input int idx, input bit expect_commit);
    done_en  = 1'b1;
    done_idx = AW'(idx);
    if (expect_commit) exp_q.push_back('{idx: AW'(idx), data: mem[idx]});
  endtask

  task automatic wait_drain(input string name, input int limit);
    int n = 0;
    while (exp_q.size() != 0 && n < limit) begin
      tick();
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: %0d entries still pending, expected 0", name, exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; done_en = 1'b1; done_idx = 4'd3; flush = 1'b1; commit_ready = 1'b1;
    tick();
    tick();
    checks += 4;
    if (commit_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b, expected 0", commit_valid); end
    if (addr_read !== 4'd0) begin errors++; $display("FAIL reset_addr: got %0d, expected 0", addr_read); end
    if (commit_idx !== 4'd0) begin errors++; $display("FAIL reset_idx: got %0d, expected 0", commit_idx); end
    if (commit_data !== 8'd0) begin errors++; $display("FAIL reset_data: got %h, expected 00", commit_data); end
    rst = 1'b0; done_en = 1'b0; flush = 1'b0;
    tick();
    tick();
    checks++;
    if (commit_valid !== 1'b0) begin errors++; $display("FAIL post_reset_valid: got %b, expected 0", commit_valid); end
  endtask

  task automatic test_single();
    mem[0] = 8'hA5;
    mark_done(0, 1'b1);
    tick();
    done_en = 1'b0;
    for (int c = 1; c <= 2; c++) begin
      checks++;
      if (commit_valid !== 1'b0) begin
        errors++; $display("FAIL single_early_valid: cycle N+%0d got %b, expected 0", c, commit_valid);
      end
      tick();
    end
    checks += 3;
    if (commit_valid !== 1'b1) begin errors++; $display("FAIL single_latency: got valid=%b at N+3, expected 1", commit_valid); end
    if (commit_idx !== 4'd0) begin errors++; $display("FAIL single_idx: got %0d, expected 0", commit_idx); end
    if (commit_data !== 8'hA5) begin errors++; $display("FAIL single_data: got %h, expected a5", commit_data); end
    tick();
    checks++;
    if (commit_valid !== 1'b0) begin errors++; $display("FAIL single_after: got valid=%b, expected 0", commit_valid); end
  endtask

  task automatic test_out_of_order();
    do_reset();
    set_pattern(8'h3C);
    mark_done(2, 1'b0); tick();
    mark_done(1, 1'b0); tick();
    mark_done(0, 1'b0);
    for (int i = 0; i < 3; i++) exp_q.push_back('{idx: AW'(i), data: mem[i]});
    tick();
    done_en = 1'b0;
    tick();
    tick();
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (commit_valid !== 1'b1 || commit_idx !== AW'(k)) begin
        errors++;
        $display("FAIL ooo_order: slot %0d got valid=%b idx=%0d, expected valid=1 idx=%0d", k, commit_valid, commit_idx, k);
      end
      tick();
    end
    checks++;
    if (commit_valid !== 1'b0) begin errors++; $display("FAIL ooo_after: got valid=%b, expected 0", commit_valid); end
  endtask

  task automatic test_backpressure();
    do_reset();
    set_pattern(8'h96);
    commit_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      mark_done(i, 1'b1);
      tick();
    end
    done_en = 1'b0;
    for (int c = 0; c < 10; c++) begin
      checks++;
      if (commit_valid !== 1'b1 || commit_idx !== 4'd0 || commit_data !== mem[0] || addr_read !== 4'd2) begin
        errors++;
        $display("FAIL bp_hold: cycle %0d got valid=%b idx=%0d data=%h head=%0d, expected 1/0/%h/2",
                 c, commit_valid, commit_idx, commit_data, addr_read, mem[0]);
      end
      tick();
    end
    commit_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      checks++;
      if (commit_valid !== 1'b1 || commit_idx !== AW'(i)) begin
        errors++;
        $display("FAIL bp_release: cycle %0d got valid=%b idx=%0d, expected valid=1 idx=%0d", i, commit_valid, commit_idx, i);
      end
      tick();
    end
    checks++;
    if (commit_valid !== 1'b0) begin errors++; $display("FAIL bp_after: got valid=%b, expected 0", commit_valid); end
    wait_drain("bp", 4);
  endtask

  task automatic test_wrap();
    do_reset();
    set_pattern(8'h3C);
    commit_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      mark_done(i % DEPTH, 1'b1);
      tick();
    end
    done_en = 1'b0;
    wait_drain("wrap", 40);
  endtask

  task automatic test_collision();
    do_reset();
    set_pattern(8'hC3);
    mark_done(0, 1'b1); tick();
    mark_done(0, 1'b0); tick();
    for (int i = 1; i < DEPTH; i++) begin
      mark_done(i, 1'b1);
      tick();
    end
    exp_q.push_back('{idx: 4'd0, data: mem[0]});
    done_en = 1'b0;
    wait_drain("collision", 40);
    tick();
    tick();
    checks++;
    if (commit_valid !== 1'b0) begin errors++; $display("FAIL collision_extra: got valid=%b, expected 0", commit_valid); end
  endtask

  task automatic test_flush();
    do_reset();
    set_pattern(8'h71);
    commit_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      mark_done(i, i < 2);
      tick();
    end
    done_en = 1'b0;
    tick(); tick(); tick();
    commit_ready = 1'b1;
    checks++;
    if (commit_idx !== 4'd0) begin errors++; $display("FAIL flush_first: got idx=%0d, expected 0", commit_idx); end
    tick();
    flush = 1'b1;
    checks++;
    if (commit_idx !== 4'd1) begin errors++; $display("FAIL flush_second: got idx=%0d, expected 1", commit_idx); end
    tick();
    flush = 1'b0;
    checks += 2;
    if (commit_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b, expected 0", commit_valid); end
    if (addr_read !== 4'd0) begin errors++; $display("FAIL flush_head: got %0d, expected 0", addr_read); end
    for (int c = 0; c < 8; c++) begin
      tick();
      checks++;
      if (commit_valid !== 1'b0) begin errors++; $display("FAIL flush_quiet: cycle %0d got valid=%b, expected 0", c, commit_valid); end
    end
    wait_drain("flush", 1);
    mark_done(0, 1'b1);
    tick();
    done_en = 1'b0;
    wait_drain("flush_restart", 8);
  endtask

  task automatic test_reset_midstream();
    set_pattern(8'h0F);
    commit_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mark_done(i, 1'b0);
      tick();
    end
    done_en = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    commit_ready = 1'b1;
    checks += 2;
    if (commit_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b, expected 0", commit_valid); end
    if (addr_read !== 4'd0) begin errors++; $display("FAIL midrst_head: got %0d, expected 0", addr_read); end
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++;
      if (commit_valid !== 1'b0) begin errors++; $display("FAIL midrst_quiet: cycle %0d got valid=%b, expected 0", c, commit_valid); end
    end
  endtask

  initial begin
    done_en = 1'b0; done_idx = '0; flush = 1'b0; commit_ready = 1'b1; rst = 1'b1;
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    #1;
    test_reset();
    test_single();
    test_out_of_order();
    test_backpressure();
    test_wrap();
    test_collision();
    test_flush();
    test_reset_midstream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
